alu_scheduler: RTL and testbench

Shares the single 32-bit integer ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare helper. The block arbitrates round-robin, latches operands, and holds the ALU for the op's latency (multi-cycle for MUL). It returns the result over one response channel tagged with the requester ID. It sits between the issue logic and the ALU datapath.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_scheduler_if.sv | 47 ++++
 rtl/alu.sv | 31 +++
 rtl/alu_scheduler.sv | 140 ++++++++++++++
 tb/tb_alu_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice.
//   - ALU op-code encodings (3 bits)
//   - scheduler state encoding (IDLE / EXEC / RESP, 2 bits)
//   - is_illegal_op(): true for the two unused op codes
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response bundle between the issue logic and the ALU scheduler.
//   req0*/req1*  : valid/ready request channels with op code and operands
//   rsp*         : single valid/ready response channel tagged with rspId
//   busy         : scheduler is not idle
// master = issue/consumer side, slave = scheduler side.
interface alu_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             req0Valid;
    logic             req0Ready;
    logic [2:0]       req0Op;
    logic [WIDTH-1:0] req0A;
    logic [WIDTH-1:0] req0B;

    logic             req1Valid;
    logic             req1Ready;
    logic [2:0]       req1Op;
    logic [WIDTH-1:0] req1A;
    logic [WIDTH-1:0] req1B;

    logic             rspValid;
    logic             rspReady;
    logic             rspId;
    logic [WIDTH-1:0] rspResult;
    logic             rspZero;

    logic             busy;

    modport master (
        output req0Valid, req0Op, req0A, req0B,
        input  req0Ready,
        output req1Valid, req1Op, req1A, req1B,
        input  req1Ready,
        input  rspValid, rspId, rspResult, rspZero, busy,
        output rspReady
    );

    modport slave (
        input  req0Valid, req0Op, req0A, req0B,
        output req0Ready,
        input  req1Valid, req1Op, req1A, req1B,
        output req1Ready,
        output rspValid, rspId, rspResult, rspZero, busy,
        input  rspReady
    );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU datapath.
//   op     : op code (see alu_pkg)
//   a, b   : operands
//   result : truncated to WIDTH bits; unused op codes give 0
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_MUL:  result = a * b;   // low WIDTH bits of the product
            // The whole of b is the shift amount; a shift of WIDTH or more
            // moves every bit out and yields 0.
            OP_SLL:  result = a << b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request channels 0/1, tagged response channel, busy
// An accepted op is latched, the ALU is held for L cycles (MUL_CYCLES for
// MUL, else 1), then the result is registered and held until rspReady.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int WIDTH      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_scheduler_if.slave  bus
);

    localparam int            CW       = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

    state_t           state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic [CW-1:0]    counter_reg, counter_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             id_reg, id_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_id_reg, rsp_id_next;
    logic [WIDTH-1:0] rsp_result_reg, rsp_result_next;
    logic             rsp_zero_reg, rsp_zero_next;

    logic             grant_id;
    logic             idle_active;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] masked_result;

    // With both valid the port that did not win last time goes; otherwise
    // whichever port is valid (port 1 only if it alone is valid).
    assign grant_id = (bus.req0Valid && bus.req1Valid) ? ~last_grant_reg : bus.req1Valid;

    // rst_n gates the readys so nothing is offered while reset is held.
    assign idle_active   = (state_reg == IDLE) && rst_n;
    assign bus.req0Ready = idle_active && bus.req0Valid && !grant_id;
    assign bus.req1Ready = idle_active && bus.req1Valid &&  grant_id;
    assign accept        = bus.req0Ready || bus.req1Ready;
    assign sel_op        = grant_id ? bus.req1Op : bus.req0Op;

    // ALU only ever sees latched operands.
    alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (alu_result)
    );

    assign masked_result = is_illegal_op(op_reg) ? '0 : alu_result;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        counter_next    = counter_reg;
        op_next         = op_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        id_next         = id_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_zero_next   = rsp_zero_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next         = sel_op;
                    a_next          = grant_id ? bus.req1A : bus.req0A;
                    b_next          = grant_id ? bus.req1B : bus.req0B;
                    id_next         = grant_id;
                    last_grant_next = grant_id;
                    counter_next    = (sel_op == OP_MUL) ? MUL_LOAD : '0;
                    state_next      = EXEC;
                end
            end
            EXEC: begin
                if (counter_reg == '0) begin
                    rsp_valid_next  = 1'b1;
                    rsp_id_next     = id_reg;
                    rsp_result_next = masked_result;
                    rsp_zero_next   = (masked_result == '0);
                    state_next      = RESP;
                end else begin
                    counter_next = counter_reg - CW'(1);
                end
            end
            RESP: begin
                if (bus.rspReady) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;   // port 0 wins the first tie
            counter_reg    <= '0;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            counter_reg    <= counter_next;
            op_reg         <= op_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            id_reg         <= id_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_zero_reg   <= rsp_zero_next;
        end
    end

    assign bus.rspValid  = rsp_valid_reg;
    assign bus.rspId     = rsp_id_reg;
    assign bus.rspResult = rsp_result_reg;
    assign bus.rspZero   = rsp_zero_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler (MUL_CYCLES=3, WIDTH=32).
module tb_alu_scheduler;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    alu_scheduler_if #(.WIDTH(32)) bus ();

    alu_scheduler #(.MUL_CYCLES(3), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            bus.req0Valid = v; bus.req0Op = op; bus.req0A = a; bus.req0B = b;
        end else begin
            bus.req1Valid = v; bus.req1Op = op; bus.req1A = a; bus.req1B = b;
        end
    endtask

    // Present an op on one port, check it is granted this cycle, let the edge accept it.
    task automatic issue(input string tag, input int port, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        drive(port, 1'b1, op, a, b);
        @(negedge clk);
        chk({tag, ":busy_idle"}, bus.busy, 1'b0);
        chk({tag, ":rdy"}, {bus.req1Ready, bus.req0Ready}, (port == 0) ? 2'b01 : 2'b10);
        @(posedge clk);
        #1;
        if (port == 0) bus.req0Valid = 1'b0; else bus.req1Valid = 1'b0;
    endtask

    // Count cycles after accept until rspValid; readys must stay low meanwhile.
    task automatic wait_rsp(input string tag, input int lat);
        int k;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            chk({tag, ":no_rdy"}, {bus.req1Ready, bus.req0Ready, bus.busy}, 3'b001);
            if (bus.rspValid) break;
        end
        chk({tag, ":latency"}, k, lat + 1);
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [31:0] res, input logic zero);
        $display("txn %s id=%0d result=%h zero=%0d", tag, bus.rspId, bus.rspResult, bus.rspZero);
        chk({tag, ":valid"},  bus.rspValid,  1'b1);
        chk({tag, ":id"},     bus.rspId,     id);
        chk({tag, ":result"}, bus.rspResult, res);
        chk({tag, ":zero"},   bus.rspZero,   zero);
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":outs"},
            {bus.rspValid, bus.rspId, bus.rspZero, bus.req0Ready, bus.req1Ready, bus.busy}, 6'b0);
        chk({tag, ":result"}, bus.rspResult, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
        drive(1, 1'b0, OP_ADD, 32'h0, 32'h0);
        bus.rspReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ADD
        issue("add", 0, OP_ADD, 32'd5, 32'd7);
        wait_rsp("add", 1);
        chk_rsp("add", 1'b0, 32'd12, 1'b0);
        finish_rsp();

        // SUB to zero, then both illegal codes
        issue("sub", 1, OP_SUB, 32'd9, 32'd9);
        wait_rsp("sub", 1);
        chk_rsp("sub", 1'b1, 32'd0, 1'b1);
        finish_rsp();
        issue("ill110", 0, 3'b110, 32'd3, 32'd4);
        wait_rsp("ill110", 1);
        chk_rsp("ill110", 1'b0, 32'd0, 1'b1);
        finish_rsp();
        issue("ill111", 1, 3'b111, 32'hFFFF_FFFF, 32'd1);
        wait_rsp("ill111", 1);
        chk_rsp("ill111", 1'b1, 32'd0, 1'b1);
        finish_rsp();
        issue("or", 0, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
        wait_rsp("or", 1);
        chk_rsp("or", 1'b0, 32'hF0F0_0F0F, 1'b0);
        finish_rsp();

        // MUL latency; req1 valid during EXEC/RESP must be ignored
        issue("mul", 0, OP_MUL, 32'd6, 32'd7);
        drive(1, 1'b1, OP_ADD, 32'd2, 32'd3);
        wait_rsp("mul", 3);
        chk_rsp("mul", 1'b0, 32'd42, 1'b0);
        finish_rsp();
        issue("add_after_mul", 1, OP_ADD, 32'd2, 32'd3);
        wait_rsp("add_after_mul", 1);
        chk_rsp("add_after_mul", 1'b1, 32'd5, 1'b0);
        finish_rsp();
        issue("mul_ovf", 0, OP_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_rsp("mul_ovf", 3);
        chk_rsp("mul_ovf", 1'b0, 32'd0, 1'b1);
        finish_rsp();

        // Backpressure with SLL
        bus.rspReady = 1'b0;
        issue("sll31", 0, OP_SLL, 32'd1, 32'd31);
        wait_rsp("sll31", 1);
        chk_rsp("sll31", 1'b0, 32'h8000_0000, 1'b0);
        drive(0, 1'b1, OP_SLL, 32'd1, 32'd32);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall:hold", {bus.rspValid, bus.req0Ready, bus.req1Ready}, 3'b100);
            chk("stall:result", bus.rspResult, 32'h8000_0000);
        end
        bus.rspReady = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release:valid_low", bus.rspValid, 1'b0);
        chk("release:accept", bus.req0Ready, 1'b1);
        @(posedge clk);
        #1 bus.req0Valid = 1'b0;
        wait_rsp("sll32", 1);
        chk_rsp("sll32", 1'b0, 32'd0, 1'b1);
        finish_rsp();

        // Reset during EXEC of a MUL (last grant was port 0)
        issue("mul_rst", 0, OP_MUL, 32'd6, 32'd7);
        @(negedge clk);
        drive(0, 1'b1, OP_ADD, 32'd0, 32'd1);
        drive(1, 1'b1, OP_ADD, 32'd1, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst:port0_first", {bus.req1Ready, bus.req0Ready}, 2'b01);
        @(posedge clk);
        #1;
        drive(0, 1'b0, OP_ADD, 32'd0, 32'd1);
        drive(1, 1'b0, OP_ADD, 32'd1, 32'd1);
        wait_rsp("rst_add", 1);
        chk_rsp("rst_add", 1'b0, 32'd1, 1'b0);
        finish_rsp();
        repeat (4) begin
            @(negedge clk);
            chk("rst:no_stale", {bus.rspValid, bus.busy}, 2'b00);
        end

        // Round-robin fairness from reset, both valid throughout
        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(0, 1'b1, OP_ADD, 32'd0, 32'd1);
        drive(1, 1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        chk_all_zero("rr_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr:grant", {bus.req1Ready, bus.req0Ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk);
            #1;
            wait_rsp("rr", 1);
            chk_rsp("rr", (i % 2 == 1), (i % 2 == 0) ? 32'd1 : 32'd2, 1'b0);
            finish_rsp();
        end
        drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        drive(1, 1'b0, OP_ADD, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
